// File: rtl/test_sequencer.sv
// Regression run controller: loads, resets, runs and checks NUM_TESTS processor programs in turn.
// Optional macro STOP_ON_FAIL_EN ends the regression at the first failing test.
module test_sequencer #(
    parameter int NUM_TESTS      = 16,
    parameter int IDX_W          = 4,
    parameter int DATA_W         = 32,
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    output logic                 load_req_o,
    input  logic                 load_ack_i,
    output logic [IDX_W-1:0]     test_idx_o,
    output logic                 cpu_rst_n_o,
    input  logic                 cpu_halt_i,
    input  logic [DATA_W-1:0]    cpu_result_i,
    input  logic [DATA_W-1:0]    expected_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [IDX_W:0]       pass_count_o,
    output logic [IDX_W:0]       fail_count_o,
    output logic [NUM_TESTS-1:0] fail_mask_o,
    output logic [NUM_TESTS-1:0] timeout_mask_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + RESET_CYCLES + 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TESTS - 1);
`ifdef STOP_ON_FAIL_EN
    localparam logic STOP_ON_FAIL = 1'b1;
`else
    localparam logic STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_CPU_RST = 3'd2,
        S_RUN     = 3'd3,
        S_CHECK   = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;
    logic [IDX_W:0]       pass_q, pass_d;
    logic [IDX_W:0]       fail_q, fail_d;
    logic [NUM_TESTS-1:0] fmask_q, fmask_d;
    logic [NUM_TESTS-1:0] tmask_q, tmask_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 load_req_q, load_req_d;
    logic                 cpu_rst_n_q, cpu_rst_n_d;
    logic                 test_ok_s;
    logic                 hit_s;

    // Next-state, bookkeeping and registered-output decode
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        fmask_d   = fmask_q;
        tmask_d   = tmask_q;
        done_d    = done_q;
        hit_s     = 1'b0;
        test_ok_s = !timeout_q && (cpu_result_i == expected_i);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    idx_d   = '0;
                    pass_d  = '0;
                    fail_d  = '0;
                    fmask_d = '0;
                    tmask_d = '0;
                    done_d  = 1'b0;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (load_ack_i) begin
                    cnt_d   = '0;
                    state_d = S_CPU_RST;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_CPU_RST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    state_d   = S_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                // Halt takes priority over a timeout landing on the same cycle
                if (cpu_halt_i) begin
                    timeout_d = 1'b0;
                    state_d   = S_CHECK;
                end else if (cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CHECK: begin
                if (test_ok_s) begin
                    pass_d = pass_q + (IDX_W + 1)'(1);
                end else begin
                    fail_d = fail_q + (IDX_W + 1)'(1);
                    for (int i = 0; i < NUM_TESTS; i++) begin
                        hit_s      = (idx_q == IDX_W'(i));
                        fmask_d[i] = fmask_q[i] | hit_s;
                        tmask_d[i] = hit_s ? timeout_q : tmask_q[i];
                    end
                end
                if ((idx_q == IDX_LAST) || (STOP_ON_FAIL && !test_ok_s)) begin
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_LOAD;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        load_req_d  = (state_d == S_LOAD);
        cpu_rst_n_d = (state_d == S_RUN);
        busy_d      = (state_d == S_LOAD) || (state_d == S_CPU_RST) ||
                      (state_d == S_RUN)  || (state_d == S_CHECK);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            pass_q      <= '0;
            fail_q      <= '0;
            fmask_q     <= '0;
            tmask_q     <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            load_req_q  <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            fmask_q     <= fmask_d;
            tmask_q     <= tmask_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            load_req_q  <= load_req_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    assign load_req_o     = load_req_q;
    assign test_idx_o     = idx_q;
    assign cpu_rst_n_o    = cpu_rst_n_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign pass_count_o   = pass_q;
    assign fail_count_o   = fail_q;
    assign fail_mask_o    = fmask_q;
    assign timeout_mask_o = tmask_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Self-checking bench for test_sequencer: a program-table CPU/loader stand-in plus a
// per-regression reference model of counts, masks and cycle budgets.
module tb_test_sequencer;

    localparam int NT = 4;
    localparam int IW = 2;
    localparam int DW = 32;
    localparam int RC = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          load_req;
    logic          load_ack;
    logic [IW-1:0] test_idx;
    logic          cpu_rst_n;
    logic          cpu_halt;
    logic [DW-1:0] cpu_result;
    logic [DW-1:0] expected;
    logic          busy;
    logic          done;
    logic [IW:0]   pass_count;
    logic [IW:0]   fail_count;
    logic [NT-1:0] fail_mask;
    logic [NT-1:0] timeout_mask;

    // Program table: expected word, produced word, halt run-cycle (-1 never), load_req cycles
    logic [DW-1:0] exp_tab [NT];
    logic [DW-1:0] res_tab [NT];
    int            halt_tab [NT];
    int            ack_tab [NT];
    int            run_cyc;
    int            wait_cnt;

    int checks;
    int failures;

    // Reference results
    logic [IW:0]   m_pass, m_fail;
    logic [NT-1:0] m_fmask, m_tmask;
    logic [IW-1:0] m_last;
    int            m_busy, m_load, m_rstlow;
    int            m_run [NT];

    // Measurements from the last regression
    int meas_busy, meas_load, meas_rstlow, meas_seen;
    int meas_run [NT];
    int meas_load_t [NT];

    logic [17:0] obs_v, exp_v;

    test_sequencer #(
        .NUM_TESTS(NT), .IDX_W(IW), .DATA_W(DW),
        .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .load_req_o(load_req), .load_ack_i(load_ack), .test_idx_o(test_idx),
        .cpu_rst_n_o(cpu_rst_n), .cpu_halt_i(cpu_halt), .cpu_result_i(cpu_result),
        .expected_i(expected), .busy_o(busy), .done_o(done),
        .pass_count_o(pass_count), .fail_count_o(fail_count),
        .fail_mask_o(fail_mask), .timeout_mask_o(timeout_mask)
    );

    always #5 clk = ~clk;

    // Processor stand-in: counts cycles out of reset, halts at its programmed cycle
    always @(posedge clk) run_cyc <= cpu_rst_n ? run_cyc + 1 : 0;
    // Loader stand-in: acknowledges after the programmed number of load_req cycles
    always @(posedge clk) wait_cnt <= load_req ? wait_cnt + 1 : 0;

    assign cpu_halt   = cpu_rst_n && (halt_tab[test_idx] >= 0) && (run_cyc >= halt_tab[test_idx]);
    assign load_ack   = load_req && (wait_cnt >= ack_tab[test_idx] - 1);
    assign cpu_result = res_tab[test_idx];
    assign expected   = exp_tab[test_idx];

    function automatic logic [17:0] observe();
        return {pass_count, fail_count, fail_mask, timeout_mask, test_idx, done, busy};
    endfunction

    // Reference: walk the program table with the pass/fail/timeout rules
    task automatic model();
        int  r;
        bit  halted, ok;
        m_pass = '0; m_fail = '0; m_fmask = '0; m_tmask = '0; m_last = '0;
        m_busy = 0; m_load = 0; m_rstlow = 0;
        for (int i = 0; i < NT; i++) m_run[i] = 0;
        for (int i = 0; i < NT; i++) begin
            halted = (halt_tab[i] >= 0) && (halt_tab[i] <= TO - 1);
            r = halted ? halt_tab[i] + 1 : TO;
            ok = halted && (res_tab[i] == exp_tab[i]);
            m_run[i] = r;
            m_load += ack_tab[i];
            m_rstlow += ack_tab[i] + RC + 1;
            m_busy += ack_tab[i] + RC + r + 1;
            m_last = IW'(i);
            if (ok) m_pass++;
            else begin
                m_fail++;
                m_fmask[i] = 1'b1;
                m_tmask[i] = !halted;
            end
`ifdef STOP_ON_FAIL_EN
            if (!ok) break;
`endif
        end
        exp_v = {m_pass, m_fail, m_fmask, m_tmask, m_last, 1'b1, 1'b0};
    endtask

    task automatic fill_pass(input int halt);
        for (int i = 0; i < NT; i++) begin
            exp_tab[i]  = $urandom;
            res_tab[i]  = exp_tab[i];
            halt_tab[i] = halt;
            ack_tab[i]  = 1;
        end
    endtask

    // Pulse start, then watch until done (bounded), optionally spraying start pulses
    task automatic run_regression(input bit inject);
        meas_busy = 0; meas_load = 0; meas_rstlow = 0; meas_seen = 0;
        for (int i = 0; i < NT; i++) begin meas_run[i] = 0; meas_load_t[i] = 0; end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (done) begin meas_seen = 1; break; end
            if (busy) meas_busy++;
            if (load_req) begin meas_load++; meas_load_t[test_idx]++; end
            if (cpu_rst_n) meas_run[test_idx]++;
            if (busy && !cpu_rst_n) meas_rstlow++;
            @(negedge clk);
            start = inject && ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        checks++;
        if (!meas_seen) begin failures++; $display("FAIL done_timeout got=0 want=1"); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (observe() !== 18'd0) begin failures++; $display("FAIL reset_state got=%h want=0", observe()); end
        checks++;
        if ({load_req, cpu_rst_n} !== 2'b00) begin failures++; $display("FAIL reset_ctrl got=%b want=00", {load_req, cpu_rst_n}); end
        start = 1'b0; rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_all_pass();
        fill_pass(10);
        model();
        run_regression(1'b0);
        checks++;
        if (observe() !== exp_v) begin failures++; $display("FAIL all_pass got=%h want=%h", observe(), exp_v); end
        checks++;
        if (meas_busy !== m_busy) begin failures++; $display("FAIL all_pass_busy got=%0d want=%0d", meas_busy, m_busy); end
        checks++;
        if (meas_run[3] !== 11) begin failures++; $display("FAIL all_pass_run got=%0d want=11", meas_run[3]); end
        @(negedge clk);
        checks++;
        if ({done, busy, cpu_rst_n} !== 3'b100) begin failures++; $display("FAIL done_held got=%b want=100", {done, busy, cpu_rst_n}); end
    endtask

    task automatic test_mismatch();
        fill_pass(10);
        exp_tab[2] = 32'h0000_0007;
        res_tab[2] = 32'hDEAD_BEEF;
        model();
        run_regression(1'b0);
        checks++;
        if (observe() !== exp_v) begin failures++; $display("FAIL mismatch got=%h want=%h", observe(), exp_v); end
        checks++;
        if (meas_busy !== m_busy) begin failures++; $display("FAIL mismatch_busy got=%0d want=%0d", meas_busy, m_busy); end
    endtask

    task automatic test_timeout();
        fill_pass(3);
        halt_tab[1] = -1;
        model();
        run_regression(1'b0);
        checks++;
        if (observe() !== exp_v) begin failures++; $display("FAIL timeout got=%h want=%h", observe(), exp_v); end
        checks++;
        if (meas_run[1] !== TO) begin failures++; $display("FAIL timeout_run got=%0d want=%0d", meas_run[1], TO); end
        checks++;
        if (meas_busy !== m_busy) begin failures++; $display("FAIL timeout_busy got=%0d want=%0d", meas_busy, m_busy); end
    endtask

    task automatic test_halt_last();
        fill_pass(5);
        halt_tab[3] = TO - 1;
        model();
        run_regression(1'b0);
        checks++;
        if (observe() !== exp_v) begin failures++; $display("FAIL halt_last got=%h want=%h", observe(), exp_v); end
        checks++;
        if (meas_run[3] !== TO) begin failures++; $display("FAIL halt_last_run got=%0d want=%0d", meas_run[3], TO); end
    endtask

    task automatic test_load_delay();
        fill_pass(4);
        ack_tab[0] = 7;
        model();
        run_regression(1'b1);
        checks++;
        if (observe() !== exp_v) begin failures++; $display("FAIL load_delay got=%h want=%h", observe(), exp_v); end
        checks++;
        if (meas_load_t[0] !== 7) begin failures++; $display("FAIL load_req_hold got=%0d want=7", meas_load_t[0]); end
        checks++;
        if (meas_rstlow !== m_rstlow) begin failures++; $display("FAIL cpu_rst_low got=%0d want=%0d", meas_rstlow, m_rstlow); end
        checks++;
        if (meas_busy !== m_busy) begin failures++; $display("FAIL load_delay_busy got=%0d want=%0d", meas_busy, m_busy); end
    endtask

    task automatic test_midrun_reset();
        int found;
        fill_pass(6);
        found = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (test_idx == 2'd2 && cpu_rst_n) begin found = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!found) begin failures++; $display("FAIL midrun_reach got=0 want=1"); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({observe(), load_req, cpu_rst_n} !== 20'd0) begin
            failures++; $display("FAIL midrun_reset got=%h want=0", {observe(), load_req, cpu_rst_n});
        end
        rst_n = 1'b1;
        @(negedge clk);
        model();
        run_regression(1'b0);
        checks++;
        if (observe() !== exp_v) begin failures++; $display("FAIL midrun_rerun got=%h want=%h", observe(), exp_v); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < NT; i++) begin
                exp_tab[i]  = $urandom;
                res_tab[i]  = ($urandom_range(0, 3) == 0) ? (exp_tab[i] ^ (32'h1 << $urandom_range(0, 31))) : exp_tab[i];
                halt_tab[i] = $urandom_range(0, TO + 3) - 1;
                ack_tab[i]  = $urandom_range(1, 5);
            end
            model();
            run_regression(1'b1);
            checks++;
            if (observe() !== exp_v) begin failures++; $display("FAIL random_%0d got=%h want=%h", it, observe(), exp_v); end
            checks++;
            if (meas_busy !== m_busy) begin failures++; $display("FAIL random_busy_%0d got=%0d want=%0d", it, meas_busy, m_busy); end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; start = 1'b0;
        fill_pass(10);
        test_reset();
        test_all_pass();
        test_mismatch();
        test_timeout();
        test_halt_last();
        test_load_delay();
        test_midrun_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
